magnitude_comparator_serial: RTL and testbench
==============================================

MAGNITUDE_COMPARATOR_SERIAL -- requirements
Module: magnitude_comparator_serial

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 1 to 64.
REQ-002 Parameter SIGNED, default 0: 0 compares unsigned; 1 compares two's-complement.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request compare; sampled only when state is IDLE or DONE.
REQ-006 a  input  WIDTH  operand A; captured on the accepting edge.
REQ-007 b  input  WIDTH  operand B; captured on the accepting edge.
REQ-008 busy  output  1  high while state is SHIFT.
REQ-009 done  output  1  one-cycle pulse; results valid in this cycle.
REQ-010 gt  output  1  A > B.
REQ-011 lt  output  1  A < B.
REQ-012 eq  output  1  A == B.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 IDLE transitions: start=1 -> SHIFT (latch a and b; set bit index to WIDTH-1); otherwise stay in IDLE.
REQ-015 SHIFT SHALL compare one bit pair per cycle, MSB first, and decrement the index each cycle.
REQ-016 SHIFT -> DONE after bit 0 has been compared (or earlier, per REQ-024). DONE lasts exactly one cycle, with done=1.
REQ-017 DONE transitions: start=1 -> SHIFT with new operands (back-to-back); otherwise -> IDLE.
REQ-018 start while in SHIFT SHALL be ignored; latched operands and progress are unaffected.
REQ-019 Exactly one of gt, lt or eq SHALL be 1 from the first done onward. All three update only on the edge entering DONE and hold until the next DONE.
REQ-020 When SIGNED=1, a differing MSB SHALL decide the result inverted: an A bit of 1 makes A the smaller operand. Lower bits SHALL compare unsigned.
REQ-021 Latency without early exit: start accepted at edge k -> done high in the cycle after edge k+WIDTH, for every operand pair.
REQ-022 When WIDTH=1, the single SHIFT cycle SHALL compare bit 0, so done follows one cycle after acceptance.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE and busy=0, done=0, gt=0, lt=0, eq=0, and clear the index and operand registers. This applies from any state, including mid-SHIFT: the compare is aborted and no done is issued.

Configuration
REQ-024 Macro MAGNITUDE_COMPARATOR_EARLY_EXIT_EN.
- Defined: SHIFT SHALL go to DONE on the first differing bit pair. For a first difference at index i, done is high in the cycle after edge k+(WIDTH-i). Equal operands still take WIDTH cycles.
- Undefined: REQ-021 fixed latency applies unconditionally, giving data-independent timing.
- The result values SHALL be identical in both builds.

Structure
REQ-025 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the index-width function clog2(WIDTH), minimum 1, SHALL reside in a shared package/include, magnitude_comparator_pkg.
REQ-026 The 1-bit compare SHALL be a sub-module, magnitude_comparator_bit_cell. It takes inputs a_bit, b_bit and invert, and outputs bit_gt and bit_lt. The top SHALL hold the FSM, index counter, operand registers and result registers.

Verification (WIDTH=8 unless noted; each scenario run in both macro builds)
REQ-027 a=0xA5, b=0xA5, SIGNED=0 -> eq=1, gt=0, lt=0; done in the cycle after edge k+8 in both builds.
REQ-028 a=0x80, b=0x7F, SIGNED=0 -> gt=1. done after edge k+1 with EARLY_EXIT_EN, after edge k+8 without.
REQ-029 a=0x80, b=0x7F, SIGNED=1 -> lt=1. a=0xFF, b=0xFE, SIGNED=1 -> gt=1 (-1 > -2).
REQ-030 Reset mid-operation: start with a=0x01, b=0x02, then rst=1 at edge k+3 -> busy=0 and outputs all 0 at the next cycle, and done never pulses. A new start then completes normally with lt=1.
REQ-031 Start handling: start held high during SHIFT (a=0x10, b=0x20, then a=0x30) -> the first result is lt=1, unaffected. A start in the DONE cycle with a=0x30, b=0x20 -> a second done with gt=1, with no IDLE cycle in between.
REQ-032 WIDTH=1: a=1, b=0 -> gt=1, done after edge k+1. a=0, b=0 -> eq=1.

Source files
------------

// File: rtl/magnitude_comparator_pkg.sv
// -----------------------------------------------------------------------------
// magnitude_comparator_pkg
// Shared definitions for the serial magnitude comparator:
//   state_t : FSM state encoding (IDLE, SHIFT, DONE)
//   clog2   : bit-index width for a given operand width (never below 1)
// -----------------------------------------------------------------------------
package magnitude_comparator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter that can hold 0 .. value-1; a 1-bit operand still
    // needs a 1-bit index register.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/magnitude_comparator_bit_cell.sv
// -----------------------------------------------------------------------------
// magnitude_comparator_bit_cell
// Compares one bit pair of the operands.
//   a_bit, b_bit : bit of operand A / B at the current index
//   invert       : high on the two's-complement sign bit; a set A bit then
//                  marks A as the smaller operand
//   bit_gt       : this bit pair alone says A > B
//   bit_lt       : this bit pair alone says A < B
// -----------------------------------------------------------------------------
module magnitude_comparator_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic invert,
    output logic bit_gt,
    output logic bit_lt
);

    logic a_only;
    logic b_only;

    always_comb begin
        a_only = a_bit & ~b_bit;
        b_only = b_bit & ~a_bit;
        bit_gt = invert ? b_only : a_only;
        bit_lt = invert ? a_only : b_only;
    end

endmodule

// File: rtl/magnitude_comparator_serial.sv
// -----------------------------------------------------------------------------
// magnitude_comparator_serial
// Bit-serial magnitude comparator, MSB first, one bit pair per clock.
// Parameters:
//   WIDTH  : operand width, 1..64
//   SIGNED : 0 = unsigned compare, 1 = two's-complement compare
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request a compare; accepted only in IDLE or DONE
//   a, b   : operands, captured on the accepting edge
//   busy   : high while bits are being compared
//   done   : one-cycle pulse, results valid in this cycle
//   gt/lt/eq : result flags, updated on entry to DONE and held until the next
// Build option:
//   MAGNITUDE_COMPARATOR_EARLY_EXIT_EN - when defined, the compare finishes on
//   the first differing bit pair; otherwise timing is data independent.
// -----------------------------------------------------------------------------
module magnitude_comparator_serial
    import magnitude_comparator_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int unsigned      IDX_W    = clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;
    logic             dec_gt;
    logic             dec_lt;
    logic             bit_gt;
    logic             bit_lt;
    logic             sign_pos;
    logic             last_bit;
    logic             res_gt;
    logic             res_lt;

    always_comb begin
        sign_pos = SIGNED && (idx == IDX_MSB);
    end

    magnitude_comparator_bit_cell u_bit_cell (
        .a_bit  (a_reg[idx]),
        .b_bit  (b_reg[idx]),
        .invert (sign_pos),
        .bit_gt (bit_gt),
        .bit_lt (bit_lt)
    );

    // The first differing bit pair (MSB first) decides the result; later bits
    // are still walked in the fixed-latency build but cannot change it.
    always_comb begin
        res_gt = (dec_gt | dec_lt) ? dec_gt : bit_gt;
        res_lt = (dec_gt | dec_lt) ? dec_lt : bit_lt;
`ifdef MAGNITUDE_COMPARATOR_EARLY_EXIT_EN
        last_bit = (idx == IDX_ZERO) || bit_gt || bit_lt;
`else
        last_bit = (idx == IDX_ZERO);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            idx    <= '0;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
        end else if (accept) begin
            a_reg  <= a;
            b_reg  <= b;
            idx    <= IDX_MSB;
            dec_gt <= 1'b0;
            dec_lt <= 1'b0;
        end else if (state == SHIFT) begin
            if (idx != IDX_ZERO) begin
                idx <= idx - IDX_ONE;
            end
            if (!dec_gt && !dec_lt) begin
                dec_gt <= bit_gt;
                dec_lt <= bit_lt;
            end
            if (last_bit) begin
                gt <= res_gt;
                lt <= res_lt;
                eq <= ~(res_gt | res_lt);
            end
        end
    end

endmodule

// File: tb/tb_magnitude_comparator_serial.sv
// -----------------------------------------------------------------------------
// tb_magnitude_comparator_serial
// Three comparator instances: WIDTH=8 unsigned, WIDTH=8 signed, WIDTH=1.
// Expected results come from integer arithmetic on the operands; a monitor
// pops them whenever done is seen and checks result flags and done timing.
// -----------------------------------------------------------------------------
module tb_magnitude_comparator_serial;

    localparam int WID [3] = '{8, 8, 1};
    localparam bit SGN [3] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        logic [2:0]  res;   // {gt, lt, eq}
        int unsigned due;   // edge number after which done must be high
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic [7:0]  a_v     [3];
    logic [7:0]  b_v     [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        gt_v    [3];
    logic        lt_v    [3];
    logic        eq_v    [3];

    exp_t        q [3][$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    magnitude_comparator_serial #(.WIDTH(8), .SIGNED(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0])
    );

    magnitude_comparator_serial #(.WIDTH(8), .SIGNED(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1])
    );

    magnitude_comparator_serial #(.WIDTH(1), .SIGNED(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
        .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .lt(lt_v[2]), .eq(eq_v[2])
    );

    task automatic chk(input string name, input int d, input logic [63:0] got,
                       input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h required %0h (t=%0t)", name, d, got, req, $time);
        end
    endtask

    // Reference: operands as plain integers, sign applied arithmetically.
    task automatic model(input logic [7:0] x, input logic [7:0] y, input int w,
                         input bit s, output logic [2:0] res, output int unsigned lat);
        longint     mask;
        longint     vx;
        longint     vy;
        logic [7:0] diff;
        bit         found;
        mask = (longint'(1) << w) - 1;
        vx   = longint'({56'd0, x}) & mask;
        vy   = longint'({56'd0, y}) & mask;
        diff = (x ^ y) & mask[7:0];
        if (s && ((vx >> (w - 1)) & 1) != 0) vx = vx - (longint'(1) << w);
        if (s && ((vy >> (w - 1)) & 1) != 0) vy = vy - (longint'(1) << w);
        if (vx > vy)      res = 3'b100;
        else if (vx < vy) res = 3'b010;
        else              res = 3'b001;
        lat   = w;
        found = 1'b0;
`ifdef MAGNITUDE_COMPARATOR_EARLY_EXIT_EN
        for (int i = w - 1; i >= 0; i--) begin
            if (!found && diff[i]) begin
                lat   = w - i;
                found = 1'b1;
            end
        end
`else
        if (found || diff != 8'd0) lat = w;
`endif
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (done_v[d]) begin
                    if (q[d].size() == 0) begin
                        chk("spurious_done", d, 64'(done_v[d]), 64'd0);
                    end else begin
                        e = q[d].pop_front();
                        chk("result", d, 64'({gt_v[d], lt_v[d], eq_v[d]}), 64'(e.res));
                        chk("latency", d, 64'(cyc), 64'(e.due));
                    end
                end
            end
        end
    end

    // Issue one compare; must be called while the DUT is not busy. During
    // 'hold' extra edges start stays high with scrambled operands.
    task automatic issue(input int d, input logic [7:0] x, input logic [7:0] y,
                         input int hold);
        logic [2:0]  r;
        int unsigned lat;
        exp_t        e;
        int          h;
        model(x, y, WID[d], SGN[d], r, lat);
        a_v[d]     = x;
        b_v[d]     = y;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        e.res = r;
        e.due = cyc + lat;
        q[d].push_back(e);
        h = (hold > int'(lat) - 1) ? int'(lat) - 1 : hold;
        for (int j = 0; j < h; j++) begin
            a_v[d] = 8'($urandom);
            b_v[d] = 8'($urandom);
            @(posedge clk);
            #1;
        end
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 200 && q[d].size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q[d].size() != 0) begin
            chk("timeout", d, 64'(q[d].size()), 64'd0);
            q[d].delete();
        end
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] m;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            a_v[d]     = '0;
            b_v[d]     = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_outs", d,
                64'({busy_v[d], done_v[d], gt_v[d], lt_v[d], eq_v[d]}), 64'd0);
        end

        // Unsigned 8-bit directed cases.
        issue(0, 8'hA5, 8'hA5, 0); wait_done(0);
        issue(0, 8'h80, 8'h7F, 0); wait_done(0);
        issue(0, 8'h10, 8'h20, 7); wait_done(0);
        issue(0, 8'h30, 8'h20, 0); wait_done(0);   // accepted in the DONE cycle

        // Reset in the middle of a compare.
        issue(0, 8'h01, 8'h02, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q[0].delete();
        chk("reset_abort", 0,
            64'({busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]}), 64'd0);
        repeat (12) @(negedge clk);
        #1;
        issue(0, 8'h01, 8'h02, 0); wait_done(0);

        // Signed 8-bit directed cases.
        issue(1, 8'h80, 8'h7F, 0); wait_done(1);
        issue(1, 8'hFF, 8'hFE, 0); wait_done(1);

        // 1-bit directed cases.
        issue(2, 8'h01, 8'h00, 0); wait_done(2);
        issue(2, 8'h00, 8'h00, 0); wait_done(2);

        // Randomized traffic with random gaps, held starts and equal pairs.
        for (int d = 0; d < 3; d++) begin
            m = (WID[d] == 1) ? 8'h01 : 8'hFF;
            for (int n = 0; n < 40; n++) begin
                x = 8'($urandom) & m;
                y = 8'($urandom) & m;
                if ($urandom_range(0, 3) == 0) y = x;
                issue(d, x, y, int'($urandom_range(0, 3)));
                wait_done(d);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                #1;
            end
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
